// File: rtl/ws2812_tx.sv
// WS2812 single-wire serialiser: RGB words in through a one-deep holding register,
// GRB out MSB first with fixed-period bit cells, latch gap closing each frame.
module ws2812_tx #(
  parameter int unsigned t0h    = 19,
  parameter int unsigned t1h    = 38,
  parameter int unsigned tbit   = 60,
  parameter int unsigned tlatch = 2880,
  parameter int unsigned nleds  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] color,
  input  logic        valid,
  output logic        ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned CMAX = (tbit > tlatch) ? tbit : tlatch;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned WW   = (nleds > 1) ? $clog2(nleds) : 1;

  localparam logic [CW-1:0] TBIT_LAST   = CW'(tbit - 1);
  localparam logic [CW-1:0] TLATCH_LAST = CW'(tlatch - 1);
  localparam logic [CW-1:0] T0H_C       = CW'(t0h);
  localparam logic [CW-1:0] T1H_C       = CW'(t1h);
  localparam logic [CW-1:0] CYC_ONE     = CW'(1);
  localparam logic [WW-1:0] WORD_LAST   = WW'(nleds - 1);
  localparam logic [WW-1:0] WORD_ONE    = WW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BIT,
    LATCH
  } state_t;

  state_t        state;
  logic [23:0]   hold_word;
  logic          hold_full;
  logic          hold_full_nxt;
  logic [23:0]   hold_grb;
  logic [23:0]   shifter;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_inc;
  logic [CW-1:0] high_len;
  logic [4:0]    bit_idx;
  logic [WW-1:0] word_cnt;
  logic          accept;
  logic          load;

  always_comb begin
    accept   = valid & ready;
    hold_grb = {hold_word[15:8], hold_word[23:16], hold_word[7:0]};
    cyc_inc  = cyc + CYC_ONE;
    high_len = shifter[23] ? T1H_C : T0H_C;
    // Every point where the FSM pulls the held word into the shifter.
    load     = hold_full &
               ((state == IDLE) ||
                (state == LATCH && cyc == TLATCH_LAST) ||
                (state == BIT && cyc == TBIT_LAST && bit_idx == 5'd23 &&
                 word_cnt < WORD_LAST));
    hold_full_nxt = accept | (hold_full & ~load);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_word <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b1;
    end else begin
      if (accept) hold_word <= color;
      hold_full <= hold_full_nxt;
      ready     <= ~hold_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shifter    <= '0;
      cyc        <= '0;
      bit_idx    <= '0;
      word_cnt   <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          dout <= 1'b0;
          busy <= 1'b0;
          if (hold_full) begin
            shifter  <= hold_grb;
            cyc      <= '0;
            bit_idx  <= '0;
            word_cnt <= '0;
            dout     <= 1'b1;
            busy     <= 1'b1;
            state    <= BIT;
          end
        end
        BIT: begin
          if (cyc == TBIT_LAST) begin
            cyc <= '0;
            if (bit_idx == 5'd23) begin
              if (load) begin
                shifter  <= hold_grb;
                bit_idx  <= '0;
                word_cnt <= word_cnt + WORD_ONE;
                dout     <= 1'b1;
              end else begin
                dout  <= 1'b0;
                state <= LATCH;
              end
            end else begin
              shifter <= {shifter[22:0], 1'b0};
              bit_idx <= bit_idx + 5'd1;
              dout    <= 1'b1;
            end
          end else begin
            // dout is registered, so it reflects the cycle index being entered.
            cyc  <= cyc_inc;
            dout <= (cyc_inc < high_len);
          end
        end
        LATCH: begin
          dout <= 1'b0;
          if (cyc == TLATCH_LAST) begin
            frame_done <= 1'b1;
            cyc        <= '0;
            if (hold_full) begin
              shifter  <= hold_grb;
              bit_idx  <= '0;
              word_cnt <= '0;
              dout     <= 1'b1;
              state    <= BIT;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cyc <= cyc_inc;
          end
        end
        default: begin
          dout  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ws2812_tx.md
# ws2812_tx

Serialises 24-bit RGB colour words into the single-wire WS2812 LED protocol. It sits directly downstream of the colour generators (e.g. `rgb_demo`), whose `out[23:0]` feeds `color`, and drives the LED strip data pin. One word is sent per LED, reordered to GRB and sent MSB first. A latch/reset gap ends each frame after `nleds` words or on input underrun.

## Interface
- `t0h`, 19: high cycles for a 0 bit (0.4 µs at 48 MHz).
- `t1h`, 38: high cycles for a 1 bit (0.8 µs).
- `tbit`, 60: total cycles per bit (1.25 µs).
- `tlatch`, 2880: low cycles of the latch gap (60 µs).
- `nleds`, 8: maximum words per frame. Must be ≥ 1.
- Constraints: 0 < `t0h` < `t1h` < `tbit`; `tlatch` ≥ 1.

- `clk`, in, 1: system clock (48 MHz).
- `rst`, in, 1: reset, synchronous, active-high.
- `color`, in, 24: {R[23:16], G[15:8], B[7:0]}.
- `valid`, in, 1: `color` is valid.
- `ready`, out, 1: the holding register is empty. A transfer occurs when `valid & ready` at a rising edge.
- `dout`, out, 1: registered serial data to the LED strip.
- `busy`, out, 1: high when the state is not IDLE.
- `frame_done`, out, 1: one-cycle pulse at the end of a latch gap.

## Operation
- Reset values: `dout`=0, `ready`=1, `busy`=0, `frame_done`=0. The holding register is empty, all counters are 0, and the state is IDLE.
- Reset mid-operation discards the held word, the in-flight word and the frame count.
- Holding register: one word deep.
  - Written on `valid & ready`.
  - `ready` = not full, driven from a register.
  - A word can be accepted in any state, including during BIT and LATCH.
- Shifter: 24 bits, loaded from the holding register as {G, R, B}. Bit 23 is sent first. Loading empties the holding register.
- Counters:
  - Cycle counter: 0..max(`tbit`, `tlatch`)−1.
  - Bit index: 0..23.
  - Word count: 0..`nleds`−1.
  - Counters wrap only via explicit clear. There is no free-running overflow.
- IDLE:
  - `dout`=0.
  - If the holding register is full: load the shifter, clear the cycle counter, bit index and word count, and go to BIT.
- BIT:
  - `dout`=1 while cycle < (current bit ? `t1h` : `t0h`), else 0.
  - At cycle = `tbit`−1, advance to the next bit and clear the cycle counter.
  - Word boundary (bit index 23, cycle `tbit`−1):
    - If the holding register is full and word count < `nleds`−1: load the shifter, increment the word count, and stay in BIT. The next bit starts with no gap.
    - Otherwise go to LATCH and clear the cycle counter.
- LATCH:
  - `dout`=0 for `tlatch` cycles.
  - After the last cycle, `frame_done`=1 for one cycle.
  - Then, if the holding register is full, start a new frame (same action as from IDLE); otherwise go to IDLE.
- Simultaneous events:
  - An accept in the same cycle as a word-boundary load: the load takes the old held word, and the new word fills the holding register on the same edge.
  - If the holding register is empty at the boundary edge, a word accepted on that edge arrives too late. The frame ends, and that word begins the next frame after LATCH.

## Timing
- Accept at edge E: the holding register is full after E, and `ready`=0.
- At edge E+1 (from IDLE): the shifter loads, `dout` rises, and `ready` returns to 1.
- Each bit is exactly `tbit` cycles.
  - 0 bit: `t0h` high, then `tbit`−`t0h` low.
  - 1 bit: `t1h` high, then `tbit`−`t1h` low.
- A word is 24·`tbit` = 1440 cycles.
- A frame of n words spans n·1440 + `tlatch` cycles, from the first `dout` rise to the `frame_done` pulse inclusive of the gap.
- `dout` is glitch-free because it comes straight from a flop.

## Test plan
- **Reset:** assert `rst` for 2 cycles, then idle 100 cycles → `dout`=0, `ready`=1, `busy`=0, `frame_done`=0 throughout.
- **Single word, `nleds`=1, `color`=24'hff0000:**
  - First 8 bits (G=00): 19 high / 41 low.
  - Next 8 bits (R=ff): 38 high / 22 low.
  - Last 8 bits (B=00): 19 high / 41 low.
  - Then 2880 low, a `frame_done` pulse, and `busy` falls.
- **Back-to-back, `nleds`=3, `valid` held with 24'h00ff00, 24'h0000ff, 24'h123456:**
  - 72 contiguous bits with no inter-word gap, in GRB order.
  - `frame_done` 72·60 + 2880 cycles after the first rise.
  - A 4th word is held until after the latch gap.
- **Underrun, `nleds`=8:** send 24'hffffff, then the second word 1500 cycles later → the frame ends after one word; the second word is sent after the 2880-cycle gap as a new frame.
- **Backpressure:** drive `valid` continuously with changing data → each accepted value is sent exactly once and in order; `ready` is low while the holding register is full.
- **Reset mid-bit** (cycle 10 of bit 5) → `dout`=0 on the next cycle; nothing resumes until a new accept.
